// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between two valid/ready requesters with a one-deep result register.
// Define ALU_ARB_PERF_EN to build the saturating per-requester grant counters.
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_op,
    input  logic [XLEN-1:0]  i_req0_a,
    input  logic [XLEN-1:0]  i_req0_b,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_op,
    input  logic [XLEN-1:0]  i_req1_a,
    input  logic [XLEN-1:0]  i_req1_b,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_resp_src,
    output logic [XLEN-1:0]  o_resp_result,
    output logic             o_resp_zero,
    output logic             o_resp_illegal,
    output logic [TAG_W-1:0] o_resp_tag,
    output logic [15:0]      o_perf_grant0,
    output logic [15:0]      o_perf_grant1
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             r_state, w_next;
    logic               r_last;
    logic               r_src, r_zero, r_illegal;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_tag;

    logic               w_can_accept, w_any, w_gnt, w_accept, w_illegal;
    logic [3:0]         w_op;
    logic [XLEN-1:0]    w_a, w_b, w_result;
    logic [TAG_W-1:0]   w_tag;
    logic [SH_W-1:0]    w_shamt;

    assign w_can_accept = (r_state == EMPTY) || i_resp_ready;
    assign w_any        = i_req0_valid || i_req1_valid;
    // On a tie the requester that did not win last time gets the slot.
    assign w_gnt        = (i_req0_valid && i_req1_valid) ? ~r_last : i_req1_valid;
    assign w_accept     = w_can_accept && w_any;
    assign o_req0_ready = w_accept && !w_gnt;
    assign o_req1_ready = w_accept && w_gnt;

    assign w_op    = w_gnt ? i_req1_op  : i_req0_op;
    assign w_a     = w_gnt ? i_req1_a   : i_req0_a;
    assign w_b     = w_gnt ? i_req1_b   : i_req0_b;
    assign w_tag   = w_gnt ? i_req1_tag : i_req0_tag;
    assign w_shamt = w_b[SH_W-1:0];

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (w_op)
            4'b0000: w_result = w_a & w_b;
            4'b0001: w_result = w_a | w_b;
            4'b0010: w_result = w_a + w_b;
            4'b0011: w_result = w_a - w_b;
            4'b0100: w_result = w_a ^ w_b;
            4'b0101: w_result = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            4'b0110: w_result = w_a << w_shamt;
            4'b0111: w_result = w_a >> w_shamt;
            4'b1000: w_result = $unsigned($signed(w_a) >>> w_shamt);
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = FULL;
        else if (i_resp_ready)
            w_next = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_last    <= 1'b1;
            r_src     <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_tag     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last    <= w_gnt;
                r_src     <= w_gnt;
                r_result  <= w_result;
                r_zero    <= (w_result == '0);
                r_illegal <= w_illegal;
                r_tag     <= w_tag;
            end
        end
    end

    assign o_resp_valid   = (r_state == FULL);
    assign o_resp_src     = r_src;
    assign o_resp_result  = r_result;
    assign o_resp_zero    = r_zero;
    assign o_resp_illegal = r_illegal;
    assign o_resp_tag     = r_tag;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf0, r_perf1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf0 <= '0;
            r_perf1 <= '0;
        end else begin
            if (o_req0_ready && r_perf0 != 16'hFFFF)
                r_perf0 <= r_perf0 + 16'd1;
            if (o_req1_ready && r_perf1 != 16'hFFFF)
                r_perf1 <= r_perf1 + 16'd1;
        end
    end

    assign o_perf_grant0 = r_perf0;
    assign o_perf_grant1 = r_perf1;
`else
    assign o_perf_grant0 = '0;
    assign o_perf_grant1 = '0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed plan cases plus randomized traffic checked against a behavioural model.
module tb_alu_share_arbiter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]       req0_op, req1_op;
    logic [XLEN-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             resp_valid, resp_ready, resp_src, resp_zero, resp_illegal;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic [15:0]      perf_grant0, perf_grant1;

    alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
        .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_tag(req0_tag),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
        .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_tag(req1_tag),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_src(resp_src),
        .o_resp_result(resp_result), .o_resp_zero(resp_zero), .o_resp_illegal(resp_illegal),
        .o_resp_tag(resp_tag), .o_perf_grant0(perf_grant0), .o_perf_grant1(perf_grant1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the consumer should currently see.
    logic             m_full, m_last, m_src, m_zero, m_ill, held0, held1;
    logic [XLEN-1:0]  m_res;
    logic [TAG_W-1:0] m_tag;
    int               m_p0, m_p1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a - b;
            4'd4: return a ^ b;
            4'd5: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd6: return a << sh;
            4'd7: return a >> sh;
            4'd8: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_full = 0; m_last = 1; m_src = 0; m_zero = 0; m_ill = 0;
        m_res = '0; m_tag = '0; m_p0 = 0; m_p1 = 0; held0 = 0; held1 = 0;
    endtask

    task automatic check_out();
        check("resp_valid", {31'd0, resp_valid}, {31'd0, m_full});
        check("resp_result", resp_result, m_res);
        check("resp_zero", {31'd0, resp_zero}, {31'd0, m_zero});
        check("resp_illegal", {31'd0, resp_illegal}, {31'd0, m_ill});
        check("resp_tag", {27'd0, resp_tag}, {27'd0, m_tag});
        check("resp_src", {31'd0, resp_src}, {31'd0, m_src});
`ifdef ALU_ARB_PERF_EN
        check("perf0", {16'd0, perf_grant0}, m_p0);
        check("perf1", {16'd0, perf_grant1}, m_p1);
`else
        check("perf0", {16'd0, perf_grant0}, 32'd0);
        check("perf1", {16'd0, perf_grant1}, 32'd0);
`endif
    endtask

    task automatic drive(input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [4:0] t0, input logic v1, input logic [3:0] o1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [4:0] t1, input logic rr);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0; req0_tag = t0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1; req1_tag = t1;
        resp_ready = rr;
    endtask

    // Called just after a rising edge with inputs already applied; checks readies, clocks, checks outputs.
    task automatic step();
        logic can, g, e0, e1;
        #1;
        can = !m_full || resp_ready;
        g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e0  = can && req0_valid && !g;
        e1  = can && req1_valid && g;
        check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        @(posedge clk);
        if (e0 || e1) begin
            m_full = 1; m_last = e1; m_src = e1;
            m_res  = e1 ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
            m_ill  = e1 ? (req1_op > 4'd8) : (req0_op > 4'd8);
            m_tag  = e1 ? req1_tag : req0_tag;
            m_zero = (m_res == 0);
            if (e0 && m_p0 < 65535) m_p0++;
            if (e1 && m_p1 < 65535) m_p1++;
        end else if (resp_ready) begin
            m_full = 0;
        end
        held0 = req0_valid && !e0;
        held1 = req1_valid && !e1;
        #1;
        check_out();
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1 check_out();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 40);
            1: return 32'h8000_0000 | $urandom_range(0, 255);
            2: return 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        drive(1, 4'b0010, 5, 7, 5'd3, 0, 0, 0, 0, 0, 1);
        step();
        check("add_result", resp_result, 32'd12);

        drive(1, 4'b1000, 32'h8000_0000, 32'h24, 5'd4, 0, 0, 0, 0, 0, 1);
        step();
        check("sra_result", resp_result, 32'hF800_0000);
        drive(1, 4'b0111, 32'h8000_0000, 32'h24, 5'd5, 0, 0, 0, 0, 0, 1);
        step();
        check("srl_result", resp_result, 32'h0800_0000);
        drive(1, 4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd6, 0, 0, 0, 0, 0, 1);
        step();
        check("slt_result", resp_result, 32'd1);

        drive(0, 0, 0, 0, 0, 1, 4'b1010, 32'h1234, 32'h5678, 5'h1F, 1);
        step();
        check("illegal_flag", {31'd0, resp_illegal}, 32'd1);
        check("illegal_tag", {27'd0, resp_tag}, 32'h1F);

        // Hold the illegal result under backpressure while both requesters wait.
        drive(1, 4'b0000, 32'hF0F0, 32'hFF00, 5'd7, 1, 4'b0001, 32'h1, 32'h2, 5'd8, 0);
        repeat (3) step();
        resp_ready = 1;
        step();
        check("bp_resume_src", {31'd0, resp_src}, 32'd0);

        do_reset();
        drive(1, 4'b0100, 32'hAAAA, 32'h5555, 5'd1, 1, 4'b0011, 32'd3, 32'd5, 5'd2, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_src", {31'd0, resp_src}, i % 2);
        end
`ifdef ALU_ARB_PERF_EN
        check("alt_perf0", {16'd0, perf_grant0}, 32'd3);
        check("alt_perf1", {16'd0, perf_grant1}, 32'd3);
`endif

        drive(1, 4'b0010, 32'd1, 32'd1, 5'd9, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 4'b0010, 32'd1, 32'd1, 5'd9, 1, 4'b0010, 32'd2, 32'd2, 5'd10, 0);
        #3 rst_n = 0;
        model_reset();
        #1 check("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        #7 rst_n = 1;
        resp_ready = 1;
        step();
        check("tie_after_rst", {31'd0, resp_src}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            if (!held0) begin
                req0_valid = $urandom_range(0, 2) != 0;
                req0_op    = 4'($urandom_range(0, 15));
                req0_a     = rand_operand();
                req0_b     = rand_operand();
                req0_tag   = 5'($urandom);
            end
            if (!held1) begin
                req1_valid = $urandom_range(0, 2) != 0;
                req1_op    = 4'($urandom_range(0, 15));
                req1_a     = rand_operand();
                req1_b     = rand_operand();
                req1_tag   = 5'($urandom);
            end
            resp_ready = $urandom_range(0, 3) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one ALU datapath between two requesters (req0: integer execute pipe, req1: address/branch helper) using round-robin arbitration with valid/ready handshakes. Accepts one operation per cycle, computes it with the team's 4-bit ALUControl encoding, and holds the result in a single output register stage until the consumer takes it. Sits in the execute stage between the ALU_CONTROL decode output and the writeback/branch logic.

Parameters:
XLEN, 32, operand/result width; shift amount is the low $clog2(XLEN) bits of operand b
TAG_W, 5, width of the opaque tag carried with each request (e.g. rd index)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  4  ALUControl code
req0_a  input  XLEN  operand a
req0_b  input  XLEN  operand b
req0_tag  input  TAG_W  opaque tag
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as req0, for requester 1
resp_valid  output  1  result register holds a valid result
resp_ready  input  1  consumer takes result this cycle
resp_src  output  1  0 = from req0, 1 = from req1
resp_result  output  XLEN  ALU result
resp_zero  output  1  resp_result == 0
resp_illegal  output  1  op code was not a defined ALUControl code
resp_tag  output  TAG_W  tag of the accepted request
perf_grant0, perf_grant1  output  16  grant counters (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_src=0, resp_result=0, resp_zero=0 (register cleared; resp_zero derived from stored flag, reset 0), resp_illegal=0, resp_tag=0, last_grant=1 (req0 wins the first tie). Reset mid-operation discards any held result; nothing is replayed.
- Two states: EMPTY (resp_valid=0), FULL (resp_valid=1).
- can_accept = !resp_valid || resp_ready (result drained this cycle frees the slot, giving full throughput).
- Grant: only req0 valid -> 0; only req1 valid -> 1; both -> requester != last_grant; none -> no grant.
- reqN_ready = can_accept && grant==N; ready is never asserted for a non-valid requester; at most one ready per cycle.
- On acceptance: register result, zero flag, illegal flag, tag, src; resp_valid=1 next cycle; last_grant <= granted index. Latency: accepted at edge N, resp_valid visible after edge N (1 cycle).
- FULL and resp_ready=0: all outputs held stable, both readies 0, last_grant unchanged.
- FULL, resp_ready=1, no valid requester: resp_valid -> 0 (EMPTY).
- Requester holding valid without ready must keep op/operands/tag stable; block does not check this.
- ALU ops: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLT (signed, result 1/0), 0110 SLL, 0111 SRL (logical), 1000 SRA (arithmetic). ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- Codes 1001-1111: result 0, resp_zero=1, resp_illegal=1; request is still consumed normally.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- Defined: perf_grant0/perf_grant1 count accepted grants per requester; 16-bit, saturate at 0xFFFF; reset to 0.
- Undefined: counters not built; perf_grant0/perf_grant1 tied to 0. Arbitration and timing identical either way.

Test Plan:
- Reset, then req0 only: op=0010, a=5, b=7, resp_ready=1 -> req0_ready=1 same cycle; next cycle resp_valid=1, result=12, src=0, zero=0.
- Both valid every cycle, resp_ready=1, 6 cycles -> grants alternate 0,1,0,1,0,1; one result per cycle; perf counters 3/3 when ALU_ARB_PERF_EN defined.
- Backpressure: result held with resp_ready=0 for 3 cycles while both requesters valid -> both readies 0, outputs stable; on resp_ready=1 the next requester in round-robin order is accepted that same cycle.
- Shifts/SLT at XLEN=32: SRA a=0x80000000 b=0x24 (shamt 4) -> 0xF8000000; SRL same -> 0x08000000; SLT a=0xFFFFFFFF b=1 -> 1.
- Illegal op 1010 from req1, tag=0x1F -> result 0, zero=1, illegal=1, tag=0x1F, src=1.
- rst_n asserted low mid-cycle while FULL -> resp_valid drops immediately (asynchronous); after release, tie goes to req0.
